fm_pack_stage: RTL and testbench

FM_PACK_STAGE -- requirements
Module: fm_pack_stage

---
 rtl/fm_pack_stage.sv | 175 +++++++++++++++++
 tb/tb_fm_pack_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fm_pack_stage.sv
// FP multiplier pack stage: applies special/overflow overrides and builds the IEEE word behind a 2-entry skid buffer.
// Optional sticky exception flags are compiled in when FM_STICKY_FLAGS_EN is defined.
module fm_pack_stage #(
    parameter int WEXP = 8,
    parameter int WSIG = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WSIG-1:0]      roundprod,
    input  logic [WEXP-1:0]      roundexp,
    input  logic                 sign,
    input  logic [1:0]           roundmode,
    input  logic                 inexact,
    input  logic                 overflow,
    input  logic                 stilltiny,
    input  logic                 denormround,
    input  logic [1:0]           specialsel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WEXP+WSIG:0]   result,
    output logic [3:0]           out_flags,
    input  logic                 flag_clr,
    output logic [3:0]           sticky_flags
);
    localparam int WRES = 1 + WEXP + WSIG;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [WRES-1:0] r_head_res;
    logic [WRES-1:0] r_skid_res;
    logic [3:0]      r_head_flg;
    logic [3:0]      r_skid_flg;
    logic [WRES-1:0] w_pack_res;
    logic [3:0]      w_pack_flg;
    logic            w_ovf_inf;
    logic            w_in_hs;
    logic            w_out_hs;

    assign w_in_hs  = in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & out_ready;

    // Overflow rounds to infinity only when the mode rounds away from zero in the sign's direction.
    assign w_ovf_inf = (roundmode == 2'b00)
                     | ((roundmode == 2'b10) & ~sign)
                     | ((roundmode == 2'b11) & sign);

    always_comb begin
        w_pack_res = {sign, roundexp, roundprod};
        w_pack_flg = {2'b00, (stilltiny | denormround) & inexact, inexact};
        case (specialsel)
            2'b11: begin
                w_pack_res = {1'b0, {WEXP{1'b1}}, 1'b1, {(WSIG-1){1'b0}}};
                w_pack_flg = 4'b1000;
            end
            2'b10: begin
                w_pack_res = {sign, {WEXP{1'b1}}, {WSIG{1'b0}}};
                w_pack_flg = 4'b0000;
            end
            2'b01: begin
                w_pack_res = {sign, {WEXP{1'b0}}, {WSIG{1'b0}}};
                w_pack_flg = 4'b0000;
            end
            default: begin
                if (overflow) begin
                    if (w_ovf_inf)
                        w_pack_res = {sign, {WEXP{1'b1}}, {WSIG{1'b0}}};
                    else
                        w_pack_res = {sign, {{(WEXP-1){1'b1}}, 1'b0}, {WSIG{1'b1}}};
                    w_pack_flg = 4'b0101;
                end
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_in_hs)
                    w_state_nxt = S_ONE;
            end
            S_ONE: begin
                if (w_in_hs && !w_out_hs)
                    w_state_nxt = S_TWO;
                else if (!w_in_hs && w_out_hs)
                    w_state_nxt = S_EMPTY;
            end
            S_TWO: begin
                if (w_out_hs)
                    w_state_nxt = S_ONE;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Handshake outputs are registered from the next state so neither depends combinationally on the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != S_TWO);
            r_out_valid <= (w_state_nxt != S_EMPTY);
        end
    end

    // Head is the oldest entry; the skid slot only fills while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_res <= '0;
            r_head_flg <= '0;
            r_skid_res <= '0;
            r_skid_flg <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_hs) begin
                        r_head_res <= w_pack_res;
                        r_head_flg <= w_pack_flg;
                    end
                end
                S_ONE: begin
                    if (w_in_hs && w_out_hs) begin
                        r_head_res <= w_pack_res;
                        r_head_flg <= w_pack_flg;
                    end else if (w_in_hs) begin
                        r_skid_res <= w_pack_res;
                        r_skid_flg <= w_pack_flg;
                    end
                end
                S_TWO: begin
                    if (w_out_hs) begin
                        r_head_res <= r_skid_res;
                        r_head_flg <= r_skid_flg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_head_res;
    assign out_flags = r_head_flg;

`ifdef FM_STICKY_FLAGS_EN
    logic [3:0] r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sticky <= 4'b0000;
        else if (flag_clr)
            r_sticky <= w_out_hs ? r_head_flg : 4'b0000;
        else if (w_out_hs)
            r_sticky <= r_sticky | r_head_flg;
    end

    assign sticky_flags = r_sticky;
`else
    logic w_unused_flag_clr;

    assign w_unused_flag_clr = flag_clr;
    assign sticky_flags      = 4'b0000;
`endif

endmodule

// File: tb/tb_fm_pack_stage.sv
// Directed bench for fm_pack_stage: packing vector table plus skid, reset and sticky-flag sequences.
module tb_fm_pack_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] roundprod;
    logic [7:0]  roundexp;
    logic        sign;
    logic [1:0]  roundmode;
    logic        inexact, overflow, stilltiny, denormround;
    logic [1:0]  specialsel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  out_flags;
    logic        flag_clr;
    logic [3:0]  sticky_flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        s;
        logic [1:0]  rm;
        logic [1:0]  sp;
        logic        ovf;
        logic        tiny;
        logic        dnr;
        logic        inx;
        logic [7:0]  e;
        logic [22:0] m;
        logic [31:0] xr;
        logic [3:0]  xf;
    } vec_t;

    vec_t vecs[13];

    fm_pack_stage #(.WEXP(8), .WSIG(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .roundprod(roundprod), .roundexp(roundexp), .sign(sign), .roundmode(roundmode),
        .inexact(inexact), .overflow(overflow), .stilltiny(stilltiny), .denormround(denormround),
        .specialsel(specialsel), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_flags(out_flags), .flag_clr(flag_clr), .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_norm(input logic s, input logic [7:0] e, input logic [22:0] m);
        sign = s; roundexp = e; roundprod = m; roundmode = 2'b00;
        specialsel = 2'b00; overflow = 1'b0; inexact = 1'b0;
        stilltiny = 1'b0; denormround = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        sign = v.s; roundmode = v.rm; specialsel = v.sp; overflow = v.ovf;
        stilltiny = v.tiny; denormround = v.dnr; inexact = v.inx;
        roundexp = v.e; roundprod = v.m;
    endtask

    // One transaction with out_ready high: visible one edge after acceptance, drained on the next.
    task automatic apply_vec(input vec_t v, input string name);
        @(negedge clk);
        drive_vec(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, " valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, " result"}, result, v.xr);
        chk({name, " flags"}, {28'd0, out_flags}, {28'd0, v.xf});
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({name, " drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        //           s     rm     sp     ovf   tiny  dnr   inx   e      m             xr            xf
        vecs[0]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 23'h000000, 32'h3F800000, 4'b0000};
        vecs[1]  = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 23'h000000, 32'h7F7FFFFF, 4'b0101};
        vecs[2]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 23'h000000, 32'hFF800000, 4'b0101};
        vecs[3]  = '{1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 23'h000000, 32'hFF7FFFFF, 4'b0101};
        vecs[4]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 23'h000000, 32'h7F800000, 4'b0101};
        vecs[5]  = '{1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 23'h000055, 32'h7FC00000, 4'b1000};
        vecs[6]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 23'h400000, 32'h00400000, 4'b0011};
        vecs[7]  = '{1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 23'h000001, 32'hFF800000, 4'b0000};
        vecs[8]  = '{1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 23'h000001, 32'h80000000, 4'b0000};
        vecs[9]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 23'h123456, 32'hC0123456, 4'b0001};
        vecs[10] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 23'h7FFFFF, 32'h00FFFFFF, 4'b0000};
        vecs[11] = '{1'b0, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 23'h000000, 32'h7FC00000, 4'b1000};
        vecs[12] = '{1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 23'h000000, 32'h7F800000, 4'b0101};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
        drive_norm(1'b0, 8'h00, 23'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset result", result, 32'd0);
        chk("reset flags", {28'd0, out_flags}, 32'd0);
        chk("reset sticky", {28'd0, sticky_flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Skid fill with the consumer stalled, then drain back-to-back.
        @(negedge clk);
        out_ready = 1'b0;
        drive_norm(1'b0, 8'h10, 23'h0000AA);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("skid A valid", {31'd0, out_valid}, 32'd1);
        chk("skid A result", result, 32'h080000AA);
        chk("skid A ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        drive_norm(1'b1, 8'h20, 23'h0000BB);
        @(posedge clk); #1;
        chk("skid B ready low", {31'd0, in_ready}, 32'd0);
        chk("skid B head held", result, 32'h080000AA);
        @(negedge clk);
        drive_norm(1'b0, 8'h30, 23'h0000CC);
        @(posedge clk); #1;
        chk("skid C refused", {31'd0, in_ready}, 32'd0);
        chk("skid C head held", result, 32'h080000AA);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain B valid", {31'd0, out_valid}, 32'd1);
        chk("drain B result", result, 32'h900000BB);
        chk("drain B ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("drain C valid", {31'd0, out_valid}, 32'd1);
        chk("drain C result", result, 32'h180000CC);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain empty", {31'd0, out_valid}, 32'd0);

        // Reset with two entries buffered.
        @(negedge clk);
        out_ready = 1'b0;
        drive_norm(1'b0, 8'h40, 23'h000011);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_norm(1'b0, 8'h41, 23'h000022);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("postrst no stale", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        drive_norm(1'b1, 8'h7F, 23'h000001);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("postrst D valid", {31'd0, out_valid}, 32'd1);
        chk("postrst D result", result, 32'hBF800001);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("postrst drained", {31'd0, out_valid}, 32'd0);

        // Sticky flags: accumulate, clear, clear coincident with a handshake.
        apply_vec(vecs[1], "stk ovf");
        apply_vec(vecs[5], "stk nan");
`ifdef FM_STICKY_FLAGS_EN
        chk("sticky accum", {28'd0, sticky_flags}, {28'd0, 4'b1101});
`else
        chk("sticky disabled", {28'd0, sticky_flags}, 32'd0);
`endif
        @(negedge clk);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("sticky clear", {28'd0, sticky_flags}, 32'd0);
        @(negedge clk);
        drive_vec(vecs[9]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
`ifdef FM_STICKY_FLAGS_EN
        chk("sticky clr+hs", {28'd0, sticky_flags}, {28'd0, 4'b0001});
`else
        chk("sticky clr ignored", {28'd0, sticky_flags}, 32'd0);
`endif
        chk("sticky seq drained", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
